// File: rtl/mips_single_cycle_top_if.sv
// Data-memory write bus of the single-cycle MIPS core: store address, data and strobe.
interface mips_single_cycle_top_if;
  logic [31:0] writedata;
  logic [31:0] dataadr;
  logic        memwrite;

  modport master (output writedata, dataadr, memwrite);
  modport slave  (input  writedata, dataadr, memwrite);
endinterface

// File: rtl/mips_single_cycle_top.sv
// Single-cycle MIPS core with an instruction ROM, a 32x32 register file and a data RAM.
// One instruction retires per rising clk; decode, ALU and memory read are combinational.
module mips_single_cycle_top #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64,
  parameter logic [IMEM_WORDS-1:0][31:0] ROM_IMAGE = {
    {(IMEM_WORDS-18){32'h0}},
    32'hac020054, 32'h20020001, 32'h08000011, 32'h8c020050,
    32'hac670044, 32'h00e23822, 32'h00853820, 32'h00e2202a,
    32'h20050000, 32'h10800001, 32'h0064202a, 32'h10a7000a,
    32'h00a42820, 32'h00642824, 32'h00e22025, 32'h2067fff7,
    32'h2003000c, 32'h20020005}
) (
  input  logic clk,
  input  logic reset,
  mips_single_cycle_top_if.master dbus
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} aluop_t;

  logic [31:0] pc, pc4, pcbr, pcnext, instr, signimm;
  logic [31:0] srca, srcb, rd2, aluresult, readdata, result;
  logic [31:0] rf [32];
  logic [31:0] dmem [DMEM_WORDS];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wa;
  logic        regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, we_mem;
  aluop_t      aluop;

  assign instr   = ROM_IMAGE[pc[IAW+1:2]];
  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign signimm = {{16{instr[15]}}, instr[15:0]};

  // Anything not decoded below falls through as a NOP: no writes, pc+4.
  always_comb begin
    regwrite = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    branch   = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    jump     = 1'b0;
    aluop    = ALU_ADD;
    case (op)
      6'h00: begin
        regdst = 1'b1;
        case (funct)
          6'h20: begin regwrite = 1'b1; aluop = ALU_ADD; end
          6'h22: begin regwrite = 1'b1; aluop = ALU_SUB; end
          6'h24: begin regwrite = 1'b1; aluop = ALU_AND; end
          6'h25: begin regwrite = 1'b1; aluop = ALU_OR;  end
          6'h2a: begin regwrite = 1'b1; aluop = ALU_SLT; end
          default: ;
        endcase
      end
      6'h23: begin regwrite = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; end
      6'h2b: begin alusrc = 1'b1; memwrite = 1'b1; end
      6'h04: begin branch = 1'b1; aluop = ALU_SUB; end
      6'h08: begin regwrite = 1'b1; alusrc = 1'b1; end
      6'h02: jump = 1'b1;
      default: ;
    endcase
  end

  // rf[0] is only ever cleared, so port reads need no $0 special case.
  assign srca = rf[rs];
  assign rd2  = rf[rt];
  assign srcb = alusrc ? signimm : rd2;

  always_comb begin
    aluresult = 32'h0;
    case (aluop)
      ALU_ADD: aluresult = srca + srcb;
      ALU_SUB: aluresult = srca - srcb;
      ALU_AND: aluresult = srca & srcb;
      ALU_OR:  aluresult = srca | srcb;
      ALU_SLT: aluresult = {31'h0, $signed(srca) < $signed(srcb)};
      default: aluresult = 32'h0;
    endcase
  end

  assign readdata = dmem[aluresult[DAW+1:2]];
  assign result   = memtoreg ? readdata : aluresult;
  assign wa       = regdst ? rd : rt;

  assign pc4    = pc + 32'd4;
  assign pcbr   = pc4 + {signimm[29:0], 2'b00};
  assign pcnext = jump ? {pc4[31:28], instr[25:0], 2'b00} :
                  (branch && aluresult == 32'h0) ? pcbr : pc4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= 32'h0;
    else        pc <= pcnext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (regwrite && wa != 5'd0) begin
      rf[wa] <= result;
    end
  end

  // The RAM keeps its contents across reset; stores are blocked while reset is held.
  assign we_mem = memwrite & reset;

  always_ff @(posedge clk) begin
    if (we_mem) dmem[aluresult[DAW+1:2]] <= rd2;
  end

  assign dbus.writedata = rd2;
  assign dbus.dataadr   = aluresult;
  assign dbus.memwrite  = we_mem;

  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];
endmodule

// File: tb/tb_mips_single_cycle_top.sv
// Bench for mips_single_cycle_top: an instruction-level MIPS interpreter predicts every cycle's
// store bus, with randomly timed asynchronous resets; a second core runs an $0/slt program.
module tb_mips_single_cycle_top;
  localparam logic [63:0][31:0] PROG2 = {
    {55{32'h0}},
    32'hac030050, 32'hac060048, 32'hac050044, 32'hac000040, 32'h0083302a,
    32'h0064282a, 32'h20040005, 32'h2003fff7, 32'h20000005};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset1 = 1'b0;
  always #5 clk = ~clk;

  mips_single_cycle_top_if bus0();
  mips_single_cycle_top_if bus1();

  mips_single_cycle_top u0 (.clk(clk), .reset(reset), .dbus(bus0));
  mips_single_cycle_top #(.ROM_IMAGE(PROG2)) u1 (.clk(clk), .reset(reset1), .dbus(bus1));

  logic [31:0] p1 [18] = '{32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025,
                           32'h00642824, 32'h00a42820, 32'h10a7000a, 32'h0064202a,
                           32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
                           32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011,
                           32'h20020001, 32'hac020054};
  logic [31:0] p2 [9] = '{32'h20000005, 32'h2003fff7, 32'h20040005, 32'h0064282a,
                          32'h0083302a, 32'hac000040, 32'hac050044, 32'hac060048,
                          32'hac030050};

  // reference machine state
  logic [31:0] mpc;
  logic [31:0] mreg [32];
  logic [31:0] mmem [64];
  logic [31:0] mrom [64];

  int nchk = 0, nerr = 0;
  int sel = 0, cyc = 0;
  bit hit9 = 1'b0;
  int st_cyc[$];
  logic [31:0] st_adr[$], st_wd[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mpc = 32'h0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
  endtask

  task automatic model_eval(output logic mw, output logic [31:0] adr, output logic [31:0] wd);
    logic [31:0] ins;
    ins = mrom[mpc[7:2]];
    mw  = (ins[31:26] == 6'h2b);
    adr = mreg[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
    wd  = mreg[ins[20:16]];
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, se, nxt;
    int rt, rd;
    ins = mrom[mpc[7:2]];
    a   = mreg[ins[25:21]];
    b   = mreg[ins[20:16]];
    rt  = int'(ins[20:16]);
    rd  = int'(ins[15:11]);
    se  = {{16{ins[15]}}, ins[15:0]};
    nxt = mpc + 4;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: mreg[rd] = a + b;
        6'h22: mreg[rd] = a - b;
        6'h24: mreg[rd] = a & b;
        6'h25: mreg[rd] = a | b;
        6'h2a: mreg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: ;
      endcase
      6'h23: mreg[rt] = mmem[(a + se) >> 2 & 32'h3f];
      6'h2b: mmem[(a + se) >> 2 & 32'h3f] = b;
      6'h08: mreg[rt] = a + se;
      6'h04: if (a == b) nxt = mpc + 4 + se * 4;
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    mreg[0] = 32'h0;
    mpc = nxt;
  endtask

  task automatic load_rom(input int which);
    for (int i = 0; i < 64; i++)
      mrom[i] = (which == 0) ? ((i < 18) ? p1[i] : 32'h0) : ((i < 9) ? p2[i] : 32'h0);
    for (int i = 0; i < 64; i++) mmem[i] = 32'h0;
    model_reset();
  endtask

  task automatic clear_log();
    cyc = 0;
    hit9 = 1'b0;
    st_cyc.delete();
    st_adr.delete();
    st_wd.delete();
  endtask

  // Compare the current cycle's bus with the model, then advance both across one rising edge.
  task automatic run_cycle(input string tag);
    logic emw, mw;
    logic [31:0] eadr, ewd, adr, wd;
    model_eval(emw, eadr, ewd);
    mw  = (sel == 0) ? bus0.memwrite  : bus1.memwrite;
    adr = (sel == 0) ? bus0.dataadr   : bus1.dataadr;
    wd  = (sel == 0) ? bus0.writedata : bus1.writedata;
    cyc++;
    if (sel == 0 && u0.pc == 32'h24) hit9 = 1'b1;
    chk({tag, " memwrite"}, {31'h0, mw}, {31'h0, emw});
    if (emw) begin
      chk({tag, " dataadr"}, adr, eadr);
      chk({tag, " writedata"}, wd, ewd);
    end
    if (mw) begin
      st_cyc.push_back(cyc);
      st_adr.push_back(adr);
      st_wd.push_back(wd);
    end
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic hold_check(input string tag);
    chk({tag, " pc"}, u0.pc, 32'h0);
    chk({tag, " instr"}, u0.instr, 32'h20020005);
    chk({tag, " memwrite"}, {31'h0, bus0.memwrite}, 32'h0);
  endtask

  // Asynchronous reset pulse placed between negedge and posedge, held for 'hold' cycles.
  task automatic pulse_reset(input int hold);
    #($urandom_range(1, 2));
    reset = 1'b0;
    #1;
    hold_check("async reset");
    model_reset();
    repeat (hold) begin
      @(negedge clk);
      #1;
      hold_check("reset hold");
    end
    reset = 1'b1;
    #1;
    clear_log();
  endtask

  task automatic check_prog1_stores(input string tag);
    chk({tag, " store count"}, st_cyc.size(), 2);
    if (st_cyc.size() == 2) begin
      chk({tag, " store0 cycle"}, st_cyc[0], 13);
      chk({tag, " store0 adr"}, st_adr[0], 32'd80);
      chk({tag, " store0 data"}, st_wd[0], 32'd7);
      chk({tag, " store1 cycle"}, st_cyc[1], 16);
      chk({tag, " store1 adr"}, st_adr[1], 32'd84);
      chk({tag, " store1 data"}, st_wd[1], 32'd7);
    end
  endtask

  initial begin
    load_rom(0);
    @(negedge clk);
    #1;
    repeat (2) begin
      @(negedge clk);
      #1;
      hold_check("initial reset");
    end
    reset = 1'b1;
    #1;
    clear_log();

    run_cycle("prog1");
    chk("first addi $2", u0.rf[2], 32'd5);
    repeat (15) run_cycle("prog1");
    chk("word9 skipped", {31'h0, hit9}, 32'h0);
    chk("$5 after run", u0.rf[5], 32'd11);
    check_prog1_stores("full run");
    repeat (9) run_cycle("nop tail");
    chk("tail store count", st_cyc.size(), 2);

    // reset in the window of cycle 10
    clear_log();
    load_rom(0);
    pulse_reset(1);
    repeat (9) run_cycle("pre-reset");
    pulse_reset(1);
    repeat (16) run_cycle("rerun");
    check_prog1_stores("rerun");

    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(0, 24);
      repeat (n) run_cycle("random pre");
      pulse_reset($urandom_range(1, 3));
      repeat (20) run_cycle("random run");
      check_prog1_stores("random rerun");
    end

    // second core: $0 protection and signed slt
    sel = 1;
    load_rom(1);
    reset1 = 1'b1;
    #1;
    clear_log();
    repeat (12) run_cycle("prog2");
    chk("prog2 $0", u1.rf[0], 32'h0);
    chk("prog2 slt -9<5", u1.rf[5], 32'd1);
    chk("prog2 store count", st_cyc.size(), 4);
    if (st_cyc.size() == 4) begin
      chk("prog2 sw $0 data", st_wd[0], 32'h0);
      chk("prog2 sw $0 adr", st_adr[0], 32'd64);
      chk("prog2 slt1 data", st_wd[1], 32'd1);
      chk("prog2 slt0 data", st_wd[2], 32'h0);
      chk("prog2 neg data", st_wd[3], 32'hfffffff7);
      chk("prog2 neg adr", st_adr[3], 32'd80);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/mips_single_cycle_top.md
Name: mips_single_cycle_top

Overview:
- Single-cycle MIPS processor subsystem: datapath, controller, 32x32 register file, instruction ROM and data RAM.
- Top of the CPU test system. Fetches and executes one instruction per clock from an on-chip ROM holding a fixed self-test program.
- Exposes the data-memory write bus so a bench can detect the final store of value 7 to address 84.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words; word index = pc[7:2].
- DMEM_WORDS, 64, data RAM depth in 32-bit words; word index = dataadr[7:2].

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- writedata  output  32  store data: register-file read port 2 (rt value).
- dataadr  output  32  ALU result, used as data-memory byte address.
- memwrite  output  1  high while the current instruction is sw.

Behaviour:
- Reset (reset=0, async): pc=0 and all 31 writable registers=0. Data RAM is not cleared. During reset, instr=ROM[0] and memwrite=0.
- Single cycle: the instruction at pc is decoded and executed combinationally. The pc, register write and RAM write commit on the next rising clk. The first instruction commits on the first rising edge after reset deasserts.
- Supported instructions:
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
  - Any other opcode or funct, including word 0, executes as a NOP: no register or memory write, pc+4.
- ALU: 32-bit, wrap-around with no overflow trap. slt is a signed compare and yields 1 or 0. addi, lw and sw use the sign-extended imm16.
- Register file:
  - Two combinational read ports.
  - One write port, written on the clock edge. The destination is rd for R-type and rt for lw/addi.
  - $0 always reads 0 and writes to it are ignored.
- lw writes the combinational RAM read data. sw writes the rt value to RAM[dataadr[7:2]] on the clock edge.
- Next pc:
  - beq with equal operands: pc+4 + (signext(imm16)<<2).
  - j: {pc+4[31:28], imm26, 2'b00}.
  - Otherwise pc+4.
- The ROM is initialised with this program, hex, addresses 0x00 onward:
  20020005, 2003000c, 2067fff7, 00e22025, 00642824, 00a42820, 10a7000a, 0064202a, 10800001, 20050000, 00e2202a, 00853820, 00e23822, ac670044, 8c020050, 08000011, 20020001, ac020054.
  All remaining ROM words are 0.
- Expected execution: 16 instructions in order 0-8, 10-15, 17.
  - Cycle 13: sw with dataadr=80, writedata=7.
  - Cycle 16: sw with dataadr=84, writedata=7.
  - Afterwards pc runs through zero words as NOPs.
- Reset asserted mid-program: pc returns to 0 immediately, regardless of clk. After release the program reruns identically.

Test Plan:
- Hold reset=0 for 2 cycles -> memwrite=0, internal pc=0; release -> first edge commits addi and $2=5.
- Run full program -> exactly two memwrite cycles: (dataadr=80, writedata=7), then (dataadr=84, writedata=7) on the 16th post-reset cycle. Declare pass at the 84/7 store.
- Branch check -> instruction 0x10a7000a (beq $5,$7) is not taken ($5=11, $7=3). Instruction 0x10800001 is taken, so ROM word 9 (addi $5,$0,0) never executes.
- Jump check -> 0x08000011 skips word 16 (addi $2,$0,1), so the final store data is 7, not 1.
- Assert reset low at cycle 10, mid-program, for 1 cycle -> pc=0 asynchronously. The rerun produces the same two stores at cycles 13 and 16 after release.
- $0 protection and slt sign check -> a modified program does addi $0,$0,5 followed by slt with a negative operand. $0 still reads 0, and slt of -9 vs 5 yields 1.
